// File: rtl/serial_word_tx_if.sv
// ============================================================================
// Module      : serial_word_tx_if
// Description : Word-in / bit-out handshake bundle for serial_word_tx.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface serial_word_tx_if #(
  parameter int N = 32
) ();
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] din;
  logic         ser_ready;
  logic         ser_valid;
  logic         ser_out;
  logic         ser_last;

  // Transmitter view
  modport master (
    input  in_valid, din, ser_ready,
    output in_ready, ser_valid, ser_out, ser_last
  );

  // Producer/consumer view
  modport slave (
    output in_valid, din, ser_ready,
    input  in_ready, ser_valid, ser_out, ser_last
  );
endinterface

`default_nettype wire

// File: rtl/serial_word_tx.sv
// ============================================================================
// Module      : serial_word_tx
// Description : Parallel-to-serial word transmitter with valid/ready on both
//               sides and a one-cycle done pulse after the final bit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_word_tx #(
  parameter int N         = 32,
  parameter bit LSB_FIRST = 1'b0
) (
  input  wire logic           clk,
  input  wire logic           rst,
  input  wire logic           clr,
  serial_word_tx_if.master    bus,
  output logic                busy,
  output logic                done
);

  localparam int            CW         = $clog2(N);
  localparam logic [CW-1:0] c_last_idx = CW'(N - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [N-1:0]   r_sr;
  logic [N-1:0]   w_sr_nxt;
  logic [CW-1:0]  r_cnt;
  logic [CW-1:0]  w_cnt_nxt;
  logic           r_done;
  logic           w_done_nxt;
  logic           w_last;
  logic           w_head;
  logic [N-1:0]   w_sr_shifted;

  assign w_last = (r_cnt == c_last_idx);
  assign w_head = LSB_FIRST ? r_sr[0] : r_sr[N-1];
  // Vacated end is zero-filled so an idle shifter always reads back as zero
  assign w_sr_shifted = LSB_FIRST ? {1'b0, r_sr[N-1:1]} : {r_sr[N-2:0], 1'b0};

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_state <= ST_IDLE;
      r_sr    <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sr    <= w_sr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_sr_nxt      = r_sr;
    w_cnt_nxt     = r_cnt;
    w_done_nxt    = 1'b0;
    bus.in_ready  = 1'b0;
    bus.ser_valid = 1'b0;
    bus.ser_out   = 1'b0;
    bus.ser_last  = 1'b0;
    busy          = 1'b0;

    case (r_state)
      ST_IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          w_sr_nxt    = bus.din;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        bus.ser_valid = 1'b1;
        bus.ser_out   = w_head;
        bus.ser_last  = w_last;
        busy          = 1'b1;
        if (bus.ser_ready) begin
          if (w_last) begin
            w_state_nxt = ST_IDLE;
            w_sr_nxt    = '0;
            w_cnt_nxt   = '0;
            w_done_nxt  = 1'b1;
          end else begin
            w_sr_nxt  = w_sr_shifted;
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign done = r_done;

endmodule

`default_nettype wire

// File: tb/tb_serial_word_tx.sv
// ============================================================================
// Module      : tb_serial_word_tx
// Description : Directed self-checking bench for serial_word_tx (two N=8
//               instances, MSB- and LSB-first, plus one N=32 instance).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_word_tx;

  logic clk = 1'b0;
  logic rst;
  logic clr_a;
  logic clr_b;
  logic clr_c;
  logic busy_a, busy_b, busy_c;
  logic done_a, done_b, done_c;

  int n_checks = 0;
  int n_fail   = 0;

  serial_word_tx_if #(.N(8))  a ();
  serial_word_tx_if #(.N(8))  b ();
  serial_word_tx_if #(.N(32)) c ();

  serial_word_tx #(.N(8), .LSB_FIRST(1'b0)) dut_a (
    .clk(clk), .rst(rst), .clr(clr_a), .bus(a), .busy(busy_a), .done(done_a)
  );
  serial_word_tx #(.N(8), .LSB_FIRST(1'b1)) dut_b (
    .clk(clk), .rst(rst), .clr(clr_b), .bus(b), .busy(busy_b), .done(done_b)
  );
  serial_word_tx #(.N(32), .LSB_FIRST(1'b0)) dut_c (
    .clk(clk), .rst(rst), .clr(clr_c), .bus(c), .busy(busy_c), .done(done_c)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Outputs depend only on registered state, so sampling 1 time unit after the edge is stable
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // MSB-first word on instance a, optionally stalling while bit stall_at is presented
  task automatic send_a(input logic [7:0] w, input int stall_at, input int stall_len);
    a.ser_ready = 1'b1;
    a.din       = w;
    a.in_valid  = 1'b1;
    check("a_accept_ready", a.in_ready, 1'b1);
    tick();
    a.in_valid  = 1'b0;
    a.din       = ~w;
    for (int i = 0; i < 8; i++) begin
      if (i == stall_at) begin
        for (int s = 0; s < stall_len; s++) begin
          a.ser_ready = 1'b0;
          check("a_stall_valid", a.ser_valid, 1'b1);
          check("a_stall_out", a.ser_out, w[7-i]);
          tick();
        end
      end
      a.ser_ready = 1'b1;
      check("a_valid", a.ser_valid, 1'b1);
      check("a_busy", busy_a, 1'b1);
      check("a_in_ready_busy", a.in_ready, 1'b0);
      check("a_bit", a.ser_out, w[7-i]);
      check("a_last", a.ser_last, (i == 7) ? 1'b1 : 1'b0);
      check("a_done_early", done_a, 1'b0);
      tick();
    end
    check("a_done", done_a, 1'b1);
    check("a_in_ready_done", a.in_ready, 1'b1);
    check("a_valid_done", a.ser_valid, 1'b0);
    tick();
    check("a_done_pulse", done_a, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  w8;
    logic [7:0]  w8b;
    logic [31:0] w32;

    rst = 1'b1;
    clr_a = 1'b0; clr_b = 1'b0; clr_c = 1'b0;
    a.in_valid = 1'b1; a.din = 8'hFF; a.ser_ready = 1'b1;
    b.in_valid = 1'b0; b.din = 8'h00; b.ser_ready = 1'b1;
    c.in_valid = 1'b0; c.din = 32'h0; c.ser_ready = 1'b1;

    // Reset held two cycles with a word offered
    for (int r = 0; r < 2; r++) begin
      tick();
      check("rst_in_ready", a.in_ready, 1'b1);
      check("rst_ser_valid", a.ser_valid, 1'b0);
      check("rst_ser_out", a.ser_out, 1'b0);
      check("rst_done", done_a, 1'b0);
      check("rst_busy", busy_a, 1'b0);
    end
    rst = 1'b0;
    a.in_valid = 1'b0;
    tick();
    check("rst_no_accept", a.ser_valid, 1'b0);
    check("rst_idle_ready", a.in_ready, 1'b1);

    send_a(8'hA5, -1, 0);

    // LSB-first on instance b
    w8 = 8'h3C;
    b.din = w8; b.in_valid = 1'b1;
    tick();
    b.in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("b_valid", b.ser_valid, 1'b1);
      check("b_bit", b.ser_out, w8[i]);
      check("b_last", b.ser_last, (i == 7) ? 1'b1 : 1'b0);
      tick();
    end
    check("b_done", done_b, 1'b1);
    tick();
    check("b_done_pulse", done_b, 1'b0);

    send_a(8'h81, 0, 3);

    // Abort mid-word
    w8 = 8'hF0;
    a.din = w8; a.in_valid = 1'b1; a.ser_ready = 1'b1;
    tick();
    a.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("abort_bit", a.ser_out, w8[7-i]);
      tick();
    end
    clr_a = 1'b1;
    tick();
    clr_a = 1'b0;
    check("abort_valid", a.ser_valid, 1'b0);
    check("abort_in_ready", a.in_ready, 1'b1);
    check("abort_busy", busy_a, 1'b0);
    check("abort_no_done", done_a, 1'b0);
    tick();
    check("abort_no_done2", done_a, 1'b0);
    send_a(8'h0F, -1, 0);

    // clr wins over a simultaneous offer in IDLE
    a.din = 8'h55; a.in_valid = 1'b1; clr_a = 1'b1;
    check("clr_in_ready", a.in_ready, 1'b1);
    tick();
    a.in_valid = 1'b0; clr_a = 1'b0;
    check("clr_no_accept", a.ser_valid, 1'b0);
    check("clr_ready_after", a.in_ready, 1'b1);

    // Offers during SHIFT are ignored; a held offer is taken in the done cycle
    w8  = 8'hC3;
    w8b = 8'h5A;
    a.din = w8; a.in_valid = 1'b1; a.ser_ready = 1'b1;
    tick();
    a.in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 2) begin
        a.din = 8'hFF; a.in_valid = 1'b1;
      end else if (i == 3) begin
        a.in_valid = 1'b0;
      end
      if (i == 6) begin
        a.din = w8b; a.in_valid = 1'b1;
      end
      check("b2b_bit1", a.ser_out, w8[7-i]);
      check("b2b_ready_busy", a.in_ready, 1'b0);
      tick();
    end
    check("b2b_done", done_a, 1'b1);
    check("b2b_ready", a.in_ready, 1'b1);
    tick();
    a.in_valid = 1'b0;
    check("b2b_done_clear", done_a, 1'b0);
    for (int i = 0; i < 8; i++) begin
      check("b2b_valid2", a.ser_valid, 1'b1);
      check("b2b_bit2", a.ser_out, w8b[7-i]);
      tick();
    end
    check("b2b_done2", done_a, 1'b1);

    // N=32 word
    w32 = 32'hDEADBEEF;
    c.din = w32; c.in_valid = 1'b1;
    tick();
    c.in_valid = 1'b0;
    for (int i = 0; i < 32; i++) begin
      check("c_bit", c.ser_out, w32[31-i]);
      check("c_last", c.ser_last, (i == 31) ? 1'b1 : 1'b0);
      tick();
    end
    check("c_done", done_c, 1'b1);
    check("c_ready", c.in_ready, 1'b1);
    tick();
    check("c_done_pulse", done_c, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/serial_word_tx.md
Name: serial_word_tx

Overview:
- Parallel-to-serial transmitter that feeds the serial input of a shift-register receiver.
- Accepts an N-bit word through a valid/ready handshake, then emits it one bit per accepted beat.
- Downstream backpressure is supported, and a one-cycle done pulse is raised after the last bit.
- Sits between a word producer and any serial consumer (e.g. a receiving shift register clocked with shR/shL).

Parameters:
- N, 32, word width in bits; N >= 2.
- LSB_FIRST, 0, 0 = transmit bit N-1 first; 1 = transmit bit 0 first.
- CW, $clog2(N), bit-counter width (derived; not overridden).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- clr  in  1  synchronous abort; same effect as rst, lower priority.
- in_valid  in  1  producer has a word on din.
- in_ready  out  1  block can accept a word.
- din  in  N  parallel word, sampled on the in_valid && in_ready edge.
- ser_ready  in  1  consumer accepts the current bit this cycle.
- ser_valid  out  1  ser_out holds a valid bit.
- ser_out  out  1  current serial bit.
- ser_last  out  1  current bit is the final bit of the word.
- busy  out  1  a word is in flight (state SHIFT).
- done  out  1  one-cycle pulse after the last bit is accepted.

Behaviour:
- Registers: state {IDLE, SHIFT}, shift reg sr[N-1:0], counter cnt[CW-1:0], done_r.
- Reset/clear (rst has priority over clr; both synchronous):
  - state=IDLE, sr=0, cnt=0, done=0.
  - Outputs: in_ready=1, ser_valid=0, ser_out=0, ser_last=0, busy=0.
  - Applies mid-word: the word in flight is dropped, with no done pulse.
- IDLE:
  - in_ready=1; ser_valid=0; ser_out=0; ser_last=0; busy=0.
  - On in_valid=1: sr<=din, cnt<=0, state<=SHIFT.
- SHIFT:
  - in_ready=0; ser_valid=1; busy=1.
  - ser_out = sr[N-1] (LSB_FIRST=0) or sr[0] (LSB_FIRST=1); combinational from sr.
  - ser_last = (cnt == N-1).
  - ser_ready=0: sr, cnt and ser_out hold; stalls may be unbounded.
  - ser_ready=1, not last: shift sr one place toward the output end, zero-fill the vacated bit; cnt<=cnt+1.
  - ser_ready=1 and ser_last: state<=IDLE, cnt<=0, sr<=0, done_r<=1.
- done:
  - Registered; high exactly one cycle, the first IDLE cycle after the last bit.
  - Cleared by any other cycle, rst or clr.
- Latency:
  - Word accepted at edge k → first bit valid in cycle k+1.
  - With ser_ready held 1, bits occupy cycles k+1..k+N; done and in_ready are high in cycle k+N+1.
  - Minimum word period N+1 cycles; no back-to-back acceptance while in SHIFT.
- in_valid during SHIFT is ignored; the producer must hold the word until in_ready.
- din changes after acceptance do not affect the word in flight.
- cnt never wraps: it is reset on the last beat.
- Simultaneous in_valid with clr in IDLE: clr wins, the word is not accepted, and in_ready stays 1.

Test Plan (N=8 unless stated):
- Reset: assert rst 2 cycles with in_valid=1, din=8'hFF → in_ready=1, ser_valid=0, ser_out=0, done=0, and no word is accepted.
- MSB-first, no stall: din=8'hA5, ser_ready=1 → ser_out 1,0,1,0,0,1,0,1 on cycles 1..8; ser_last only on cycle 8; done=1 on cycle 9 only.
- LSB_FIRST=1, din=8'h3C, ser_ready=1 → ser_out 0,0,1,1,1,1,0,0.
- Backpressure: din=8'h81, ser_ready low for 3 cycles after bit 0 → ser_out stays 1 with ser_valid=1 while stalled; remaining bits unchanged; total 11 cycles to done.
- Abort: clr pulsed after 4 bits of 8'hF0 → next cycle IDLE, ser_valid=0, no done pulse; a following 8'h0F transmits correctly.
- Busy ignore + back-to-back: change din and pulse in_valid mid-word → ignored; hold in_valid with new din → accepted in the done cycle; next first bit in the cycle after; N=32 with 32'hDEADBEEF → 32 correct bits.
